// File: rtl/riscv_run_controller.sv
// Run-control sequencer for the single-cycle RISC-V core: core reset hold, cycle budget, halt-PC detection.
// Optional stall-based halt detection is built only when STALL_DETECT_EN is defined.
module riscv_run_controller #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned RST_CYCLES  = 2,
  parameter int unsigned MAX_CYCLES  = 64,
  parameter int unsigned STALL_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  halt_addr,
  output logic             core_rst_n,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic             stalled,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [XLEN-1:0]  final_pc
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CORE_RST = 3'd1;
  localparam logic [2:0] S_RUN      = 3'd2;
  localparam logic [2:0] S_DONE     = 3'd3;
  localparam logic [2:0] S_TIMEOUT  = 3'd4;

  localparam int unsigned     RCW      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0]  RST_LAST = RCW'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

  if (RST_CYCLES < 1 || MAX_CYCLES < 1 || STALL_LIMIT < 1 || (MAX_CYCLES >> CNT_W) != 0)
  begin : g_bad_params
    $error("riscv_run_controller: parameter out of range");
  end

  logic [2:0]       state_q, state_d;
  logic [RCW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [XLEN-1:0]  final_pc_q, final_pc_d;
  logic             stalled_q, stalled_d;
  logic             core_rst_n_q, running_q, done_q, timeout_q;
  logic             halt_hit, stall_hit, budget_hit;

  assign halt_hit   = (pc == halt_addr);
  assign budget_hit = (cycle_cnt_q == CNT_LAST);

`ifdef STALL_DETECT_EN
  localparam int unsigned    SCW        = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;
  localparam logic [SCW-1:0] STALL_LAST = SCW'(STALL_LIMIT - 1);

  logic [SCW-1:0]  stall_cnt_q;
  logic [XLEN-1:0] prev_pc_q;
  logic            prev_vld_q;
  logic            pc_same;

  // The first RUN cycle has no previous sample, so prev_vld_q gates the comparison.
  assign pc_same   = prev_vld_q && (pc == prev_pc_q);
  assign stall_hit = pc_same && (stall_cnt_q == STALL_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      prev_pc_q   <= '0;
      prev_vld_q  <= 1'b0;
    end else if (state_q == S_RUN) begin
      stall_cnt_q <= pc_same ? stall_cnt_q + SCW'(1) : '0;
      prev_pc_q   <= pc;
      prev_vld_q  <= 1'b1;
    end else begin
      stall_cnt_q <= '0;
      prev_vld_q  <= 1'b0;
    end
  end
`else
  assign stall_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    final_pc_d  = final_pc_q;
    stalled_d   = stalled_q;
    case (state_q)
      S_IDLE, S_DONE, S_TIMEOUT: begin
        if (start) begin
          state_d     = S_CORE_RST;
          rst_cnt_d   = '0;
          cycle_cnt_d = '0;
          final_pc_d  = '0;
          stalled_d   = 1'b0;
        end
      end
      S_CORE_RST: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d   = S_RUN;
          rst_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + RCW'(1);
        end
      end
      S_RUN: begin
        cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        // Halt match wins over stall, stall wins over budget exhaustion.
        if (halt_hit) begin
          state_d    = S_DONE;
          final_pc_d = pc;
        end else if (stall_hit) begin
          state_d    = S_DONE;
          final_pc_d = pc;
          stalled_d  = 1'b1;
        end else if (budget_hit) begin
          state_d    = S_TIMEOUT;
          final_pc_d = pc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      rst_cnt_q    <= '0;
      cycle_cnt_q  <= '0;
      final_pc_q   <= '0;
      stalled_q    <= 1'b0;
      core_rst_n_q <= 1'b0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      cycle_cnt_q  <= cycle_cnt_d;
      final_pc_q   <= final_pc_d;
      stalled_q    <= stalled_d;
      core_rst_n_q <= (state_d == S_RUN) || (state_d == S_DONE) || (state_d == S_TIMEOUT);
      running_q    <= (state_d == S_RUN);
      done_q       <= (state_d == S_DONE);
      timeout_q    <= (state_d == S_TIMEOUT);
    end
  end

  assign core_rst_n = core_rst_n_q;
  assign running    = running_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign stalled    = stalled_q;
  assign cycle_cnt  = cycle_cnt_q;
  assign final_pc   = final_pc_q;

endmodule

// File: tb/tb_riscv_run_controller.sv
// Bench for riscv_run_controller: fixed vector table, hand sequences for reset/restart, random programs vs a reference model.
module tb_riscv_run_controller;

  localparam int RSTC = 2;
  localparam int MAXC = 64;
  localparam int SLIM = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] halt_addr = '0;
  logic        core_rst_n, running, done, timeout, stalled;
  logic [15:0] cycle_cnt;
  logic [31:0] final_pc;

  int errors = 0;
  int checks = 0;
  logic [31:0] pcs [MAXC];

  riscv_run_controller #(
    .XLEN(32), .CNT_W(16), .RST_CYCLES(RSTC), .MAX_CYCLES(MAXC), .STALL_LIMIT(SLIM)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pc(pc), .halt_addr(halt_addr),
    .core_rst_n(core_rst_n), .running(running), .done(done), .timeout(timeout),
    .stalled(stalled), .cycle_cnt(cycle_cnt), .final_pc(final_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_core_rst_n"}, core_rst_n, 0);
    chk({tag, "_running"}, running, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_stalled"}, stalled, 0);
    chk({tag, "_cycle_cnt"}, cycle_cnt, 0);
    chk({tag, "_final_pc"}, final_pc, 0);
  endtask

  // Outcome from the rules: first halt match ends with DONE; a window of SLIM+1
  // identical samples ends with DONE+stalled; otherwise the last budget cycle times out.
  // kind: 0 done, 1 timeout, 2 stall-done.
  function automatic void predict(input logic [31:0] halt, output int idx, output int kind);
    idx = MAXC - 1;
    kind = 1;
    for (int i = 0; i < MAXC; i++) begin
      bit same;
      if (pcs[i] == halt) begin idx = i; kind = 0; return; end
      same = 1'b0;
`ifdef STALL_DETECT_EN
      if (i >= SLIM) begin
        same = 1'b1;
        for (int j = 1; j <= SLIM; j++) if (pcs[i-j] != pcs[i]) same = 1'b0;
      end
`endif
      if (same) begin idx = i; kind = 2; return; end
    end
  endfunction

  // Assumes the caller is at a falling edge; returns at a falling edge with the run finished.
  task automatic run_prog(input logic [31:0] halt, input int glitch);
    int idx, kind;
    predict(halt, idx, kind);
    halt_addr = halt;
    pc = halt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("entry_done_clr", done, 0);
    chk("entry_timeout_clr", timeout, 0);
    chk("entry_cnt_clr", cycle_cnt, 0);
    chk("entry_final_clr", final_pc, 0);
    chk("entry_stalled_clr", stalled, 0);
    for (int r = 0; r < RSTC; r++) begin
      chk("core_rst_low", core_rst_n, 0);
      chk("core_rst_not_running", running, 0);
      @(negedge clk);
    end
    for (int i = 0; i <= idx; i++) begin
      chk("run_running", running, 1);
      chk("run_core_rst_n", core_rst_n, 1);
      chk("run_cycle_cnt", cycle_cnt, i);
      pc = pcs[i];
      start = (i == glitch);
      @(negedge clk);
      start = 1'b0;
    end
    for (int h = 0; h < 2; h++) begin
      chk("end_running", running, 0);
      chk("end_core_rst_n", core_rst_n, 1);
      chk("end_done", done, kind != 1);
      chk("end_timeout", timeout, kind == 1);
      chk("end_stalled", stalled, kind == 2);
      chk("end_cycle_cnt", cycle_cnt, idx + 1);
      chk("end_final_pc", final_pc, pcs[idx]);
      pc = pc + 32'd4;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [31:0] halt;
    logic [31:0] base;
    logic [31:0] step;
    int          hold_from;
    logic [31:0] hold_val;
    logic        exp_done;
    logic        exp_to;
    logic        exp_st;
    int          exp_cnt;
    logic [31:0] exp_final;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{32'h1C,  32'h0,  32'd4, 1000, 32'h0,  1'b1, 1'b0, 1'b0, 8,  32'h1C};
    vecs[1] = '{32'hFFC, 32'h0,  32'd4, 1000, 32'h0,  1'b0, 1'b1, 1'b0, 64, 32'hFC};
    vecs[2] = '{32'h0,   32'h0,  32'd4, 1000, 32'h0,  1'b1, 1'b0, 1'b0, 1,  32'h0};
    vecs[3] = '{32'hFC,  32'h0,  32'd4, 1000, 32'h0,  1'b1, 1'b0, 1'b0, 64, 32'hFC};
    vecs[4] = '{32'hF8,  32'h0,  32'd4, 1000, 32'h0,  1'b1, 1'b0, 1'b0, 63, 32'hF8};
    vecs[5] = '{32'hC0,  32'h80, 32'd8, 1000, 32'h0,  1'b1, 1'b0, 1'b0, 9,  32'hC0};
`ifdef STALL_DETECT_EN
    vecs[6] = '{32'hFFC, 32'h0,  32'd4, 3,    32'h10, 1'b1, 1'b0, 1'b1, 8,  32'h10};
`else
    vecs[6] = '{32'hFFC, 32'h0,  32'd4, 3,    32'h10, 1'b0, 1'b1, 1'b0, 64, 32'h10};
`endif

    // Power-on reset, then release into IDLE with pc matching halt_addr.
    repeat (2) @(negedge clk);
    chk_reset_outputs("por");
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_running", running, 0);
    chk("idle_core_rst_n", core_rst_n, 0);
    chk("idle_done", done, 0);

    foreach (vecs[v]) begin
      for (int i = 0; i < MAXC; i++)
        pcs[i] = (i >= vecs[v].hold_from) ? vecs[v].hold_val : vecs[v].base + vecs[v].step * i;
      run_prog(vecs[v].halt, (v == 0) ? 3 : -1);
      chk("vec_done", done, vecs[v].exp_done);
      chk("vec_timeout", timeout, vecs[v].exp_to);
      chk("vec_stalled", stalled, vecs[v].exp_st);
      chk("vec_cycle_cnt", cycle_cnt, vecs[v].exp_cnt);
      chk("vec_final_pc", final_pc, vecs[v].exp_final);
    end

    // Asynchronous reset from DONE with start low, mid-cycle.
    for (int i = 0; i < MAXC; i++) pcs[i] = 32'h200 + 4 * i;
    run_prog(32'h210, -1);
    #3 rst = 1'b0;
    #1 chk_reset_outputs("async_done");
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle_running", running, 0);
    chk("post_rst_idle_core", core_rst_n, 0);

    // Asynchronous reset at RUN cycle 10.
    halt_addr = 32'hFFC;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (RSTC) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      pc = 4 * i;
      @(negedge clk);
    end
    chk("run10_cycle_cnt", cycle_cnt, 10);
    #3 rst = 1'b0;
    #1 chk_reset_outputs("async_run");
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("run10_idle_running", running, 0);
    chk("run10_idle_core", core_rst_n, 0);
    chk("run10_idle_cnt", cycle_cnt, 0);

    // Random programs, each started from the previous run's DONE/TIMEOUT.
    for (int t = 0; t < 16; t++) begin
      int mode;
      int hold;
      logic [31:0] base, halt;
      mode = $urandom_range(0, 3);
      base = {$urandom_range(0, 4095), 2'b00};
      hold = $urandom_range(1, MAXC - 1);
      for (int i = 0; i < MAXC; i++) begin
        case (mode)
          0: pcs[i] = base + 4 * i;
          1: pcs[i] = {$urandom_range(0, 63), 2'b00};
          2: pcs[i] = (i >= hold) ? pcs[hold - 1] : base + 4 * i;
          default: pcs[i] = (i > 0 && $urandom_range(0, 1) == 1) ? pcs[i-1] : base + 4 * i;
        endcase
      end
      halt = ($urandom_range(0, 1) == 1) ? pcs[$urandom_range(0, MAXC - 1)] : 32'hFFFF_0000 | $urandom_range(0, 255);
      run_prog(halt, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 8) : -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
